// File: rtl/div_pkg.sv
// Shared definitions for the two-requester divider front end.
package div_pkg;

    localparam int W_DEF       = 32;
    localparam int TIMEOUT_DEF = 48;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_ZCHK = 3'd1;
    localparam state_t S_CLR  = 3'd2;
    localparam state_t S_RUN  = 3'd3;
    localparam state_t S_WAIT = 3'd4;
    localparam state_t S_RESP = 3'd5;

    localparam int ERR_DZ = 0;
    localparam int ERR_TO = 1;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; ptr breaks ties when both request.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       id
);

    always_comb begin
        id    = (req == 2'b11) ? ptr : req[1];
        grant = 2'b00;
        if (req != 2'b00)
            grant = id ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters with
// divide-by-zero bypass and a hung-divider timeout.
module div_arbiter
    import div_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           Rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_dvnd,
    input  logic [2*W-1:0] req_dvsr,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [W-1:0]   resp_q,
    output logic [W-1:0]   resp_r,
    output logic [1:0]     resp_err,
    output logic           div_rst,
    output logic           div_run,
    output logic [W-1:0]   div_dvsr,
    output logic [W-1:0]   div_dvnd,
    input  logic [W-1:0]   div_q,
    input  logic [W-1:0]   div_r,
    input  logic           div_rdy,
    output logic           busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state;
    logic           rr_ptr;
    logic           owner;
    logic [W-1:0]   op_dvnd;
    logic [W-1:0]   op_dvsr;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic [1:0]     err;
    logic [CW-1:0]  cnt;
    logic [1:0]     grant;
    logic           win;

    rr_arb2 u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .id    (win)
    );

    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        if (!Rst && state == S_IDLE)
            req_ready = grant;
        if (!Rst && state == S_RESP)
            resp_valid = onehot2(owner);
    end

    assign div_rst  = Rst || (state == S_CLR);
    assign div_run  = !Rst && (state == S_RUN);
    assign div_dvsr = op_dvsr;
    assign div_dvnd = op_dvnd;
    assign resp_q   = q;
    assign resp_r   = r;
    assign resp_err = err;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (Rst) begin
            state   <= S_IDLE;
            rr_ptr  <= 1'b0;
            owner   <= 1'b0;
            op_dvnd <= '0;
            op_dvsr <= '0;
            q       <= '0;
            r       <= '0;
            err     <= 2'b00;
            cnt     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid != 2'b00) begin
                        owner   <= win;
                        rr_ptr  <= ~win;
                        op_dvnd <= win ? req_dvnd[2*W-1:W]
                                       : req_dvnd[W-1:0];
                        op_dvsr <= win ? req_dvsr[2*W-1:W]
                                       : req_dvsr[W-1:0];
                        state   <= S_ZCHK;
                    end
                end
                S_ZCHK: begin
                    if (op_dvsr == '0) begin
                        q           <= '1;
                        r           <= op_dvnd;
                        err         <= 2'b00;
                        err[ERR_DZ] <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        state <= S_CLR;
                    end
                end
                S_CLR: state <= S_RUN;
                S_RUN: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // cnt==0 marks the first WAIT cycle, where rdy may be stale
                    if (cnt != '0 && div_rdy) begin
                        q     <= div_q;
                        r     <= div_r;
                        err   <= 2'b00;
                        state <= S_RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        q           <= '0;
                        r           <= '0;
                        err         <= 2'b00;
                        err[ERR_TO] <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready[owner])
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized scoreboard bench for div_arbiter with a stub divider.
module tb_div_arbiter;

    localparam int W  = 32;
    localparam int TO = 48;

    logic           clk = 1'b0;
    logic           Rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_dvnd;
    logic [2*W-1:0] req_dvsr;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [W-1:0]   resp_q;
    logic [W-1:0]   resp_r;
    logic [1:0]     resp_err;
    logic           div_rst;
    logic           div_run;
    logic [W-1:0]   div_dvsr;
    logic [W-1:0]   div_dvnd;
    logic [W-1:0]   div_q;
    logic [W-1:0]   div_r;
    logic           div_rdy;
    logic           busy;

    always #5 clk = ~clk;

    div_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dvnd   (req_dvnd),
        .req_dvsr   (req_dvsr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_q     (resp_q),
        .resp_r     (resp_r),
        .resp_err   (resp_err),
        .div_rst    (div_rst),
        .div_run    (div_run),
        .div_dvsr   (div_dvsr),
        .div_dvnd   (div_dvnd),
        .div_q      (div_q),
        .div_r      (div_r),
        .div_rdy    (div_rdy),
        .busy       (busy)
    );

    typedef struct {
        int           id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [1:0]   err;
        bit           dz;
        int           tacc;
    } exp_t;

    exp_t       sbq[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         run_cnt = 0;
    int         rst_cnt = 0;
    bit         ptr_m = 1'b0;
    bit         m_busy = 1'b0;
    bit         seen = 1'b0;
    bit         hang = 1'b0;
    logic [1:0] acc = 2'b00;

    // Stub divider: variable latency, optional hang
    logic [W-1:0] sq = '0;
    logic [W-1:0] sr = '0;
    logic         srdy = 1'b0;
    logic         sact = 1'b0;
    int           scnt = 0;

    assign div_q   = sq;
    assign div_r   = sr;
    assign div_rdy = srdy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!Rst && div_run) run_cnt <= run_cnt + 1;
        if (!Rst && div_rst) rst_cnt <= rst_cnt + 1;
        if (Rst || div_rst) begin
            srdy <= 1'b0;
            sact <= 1'b0;
        end else if (div_run) begin
            sact <= 1'b1;
            srdy <= 1'b0;
            scnt <= $urandom_range(0, 6);
            sq   <= (div_dvsr != 0) ? div_dvnd / div_dvsr : '1;
            sr   <= (div_dvsr != 0) ? div_dvnd % div_dvsr : '0;
        end else if (sact && !hang) begin
            if (scnt == 0) srdy <= 1'b1;
            else scnt <= scnt - 1;
        end
    end

    // Reference model + monitor
    always @(negedge clk) begin
        logic [1:0]   exp_rdy;
        int           win;
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        acc = 2'b00;
        if (Rst) begin
            sbq.delete();
            ptr_m  = 1'b0;
            m_busy = 1'b0;
            seen   = 1'b0;
        end else begin
            exp_rdy = 2'b00;
            win = 0;
            if (!m_busy && req_valid != 2'b00) begin
                if (req_valid == 2'b11) win = ptr_m ? 1 : 0;
                else win = req_valid[1] ? 1 : 0;
                exp_rdy = (win == 1) ? 2'b10 : 2'b01;
            end
            if (req_valid != 2'b00 || req_ready != 2'b00) begin
                tests++;
                if (req_ready !== exp_rdy) begin
                    fails++;
                    $display("FAIL req_ready @%0d: got %b want %b",
                             cyc, req_ready, exp_rdy);
                end
            end
            if (exp_rdy != 2'b00) begin
                a = (win == 1) ? req_dvnd[2*W-1:W] : req_dvnd[W-1:0];
                b = (win == 1) ? req_dvsr[2*W-1:W] : req_dvsr[W-1:0];
                e.id = win;
                e.tacc = cyc;
                e.dz = (b == 0);
                if (b == 0) begin
                    e.q = '1; e.r = a; e.err = 2'b01;
                end else if (hang) begin
                    e.q = '0; e.r = '0; e.err = 2'b10;
                end else begin
                    e.q = a / b; e.r = a % b; e.err = 2'b00;
                end
                sbq.push_back(e);
                ptr_m  = (win == 0);
                m_busy = 1'b1;
                acc[win] = 1'b1;
            end
            if (resp_valid != 2'b00) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL resp_unexpected @%0d: got v=%b want none",
                             cyc, resp_valid);
                end else begin
                    e = sbq[0];
                    if (resp_valid !== ((e.id == 1) ? 2'b10 : 2'b01) ||
                        resp_q !== e.q || resp_r !== e.r ||
                        resp_err !== e.err) begin
                        fails++;
                        $display("FAIL resp @%0d: got v=%b q=%h r=%h e=%b want id=%0d q=%h r=%h e=%b",
                                 cyc, resp_valid, resp_q, resp_r, resp_err,
                                 e.id, e.q, e.r, e.err);
                    end
                    if (!seen && e.dz) begin
                        tests++;
                        if (cyc - e.tacc != 2) begin
                            fails++;
                            $display("FAIL dz_latency: got %0d want 2",
                                     cyc - e.tacc);
                        end
                    end
                    seen = 1'b1;
                    if (resp_ready[e.id]) begin
                        void'(sbq.pop_front());
                        m_busy = 1'b0;
                        seen   = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_valid[i] = 1'b1;
        req_dvnd[i*W +: W] = a;
        req_dvsr[i*W +: W] = b;
    endtask

    task automatic wait_acc(input int i);
        int n = 0;
        while (n < 200) begin
            @(posedge clk);
            if (acc[i]) break;
            n++;
        end
        #1;
        req_valid[i] = 1'b0;
        chk("accept_timeout", 64'(n >= 200), 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 500) begin
            tick();
            if (sbq.size() == 0 && !m_busy) break;
            n++;
        end
        chk("idle_timeout", 64'(n >= 500), 64'd0);
    endtask

    initial begin
        int r0;
        int s0;
        int n;
        logic [3:0] order;
        Rst = 1'b1;
        req_valid = 2'b00;
        req_dvnd = '0;
        req_dvsr = '0;
        resp_ready = 2'b11;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_div_rst", 64'(div_rst), 64'd1);
        chk("rst_div_run", 64'(div_run), 64'd0);
        chk("rst_q", 64'(resp_q), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        Rst = 1'b0;
        tick();
        chk("div_rst_low", 64'(div_rst), 64'd0);

        // single op on requester 0
        r0 = run_cnt; s0 = rst_cnt;
        set_req(0, 32'd100, 32'd7);
        wait_acc(0);
        wait_idle();
        chk("single_run_pulses", 64'(run_cnt - r0), 64'd1);
        chk("single_rst_pulses", 64'(rst_cnt - s0), 64'd1);

        // divide by zero never touches the divider
        r0 = run_cnt; s0 = rst_cnt;
        set_req(1, 32'h1234, 32'd0);
        wait_acc(1);
        wait_idle();
        chk("dz_run_pulses", 64'(run_cnt - r0), 64'd0);
        chk("dz_rst_pulses", 64'(rst_cnt - s0), 64'd0);

        // hung divider
        hang = 1'b1;
        set_req(0, 32'd500, 32'd5);
        wait_acc(0);
        wait_idle();
        hang = 1'b0;
        chk("to_busy", 64'(busy), 64'd0);

        // backpressure on requester 1
        resp_ready = 2'b01;
        set_req(1, 32'd77, 32'd5);
        wait_acc(1);
        n = 0;
        while (resp_valid != 2'b10 && n < 100) begin
            tick(); n++;
        end
        chk("bp_resp_seen", 64'(resp_valid), 64'h2);
        set_req(0, 32'd9, 32'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 2'b11;
        wait_acc(0);
        wait_idle();

        // reset while waiting on a hung divider
        hang = 1'b1;
        set_req(0, 32'd50, 32'd3);
        wait_acc(0);
        repeat (6) tick();
        chk("mid_busy", 64'(busy), 64'd1);
        Rst = 1'b1;
        @(negedge clk);
        chk("mid_div_rst", 64'(div_rst), 64'd1);
        tick();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_resp", 64'(resp_valid), 64'd0);
        chk("mid_rst_divrst", 64'(div_rst), 64'd1);
        Rst = 1'b0;
        hang = 1'b0;
        tick();

        // contention from rr_ptr=0 with continuous load
        set_req(0, 32'd1000, 32'd10);
        set_req(1, 32'hFFFF_FFFF, 32'd3);
        order = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (n < 200) begin
                @(posedge clk);
                if (acc != 2'b00) break;
                n++;
            end
            order[k] = acc[1];
        end
        #1;
        req_valid = 2'b00;
        chk("rr_order", 64'(order), 64'b1010);
        wait_idle();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 7))
                        0: set_req(i, $urandom, 32'd0);
                        1, 2, 3: set_req(i, $urandom, $urandom_range(1, 20));
                        default: set_req(i, $urandom, $urandom);
                    endcase
                end else if (req_valid[i] && $urandom_range(0, 30) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = 2'($urandom);
        end
        req_valid = 2'b00;
        resp_ready = 2'b11;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
